// File: rtl/mpc_mac_pipe.sv
// Four-stage pipelined signed multiply-accumulate with round-half-up, shift and narrowing.
// Define MPC_MAC_SAT_EN to clamp the narrowed result and report clamping on ovf.
module mpc_mac_pipe #(
   parameter int A_W   = 21,
   parameter int B_W   = 13,
   parameter int ACC_W = 40,
   parameter int SHIFT = 10,
   parameter int OUT_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic                    in_valid,
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   input  logic                    acc_first,
   input  logic                    acc_last,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] p,
   output logic                    ovf
);

   localparam int PROD_W = A_W + B_W;

   // Half an output LSB, expressed at accumulator scale (zero when SHIFT is 0).
   localparam logic signed [ACC_W:0] ROUND_K = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;

   // S1: input capture
   logic signed [A_W-1:0]    s1_a_reg;
   logic signed [B_W-1:0]    s1_b_reg;
   logic                     s1_valid_reg;
   logic                     s1_first_reg;
   logic                     s1_last_reg;

   // S2: product
   logic signed [PROD_W-1:0] prod_next;
   logic signed [PROD_W-1:0] s2_prod_reg;
   logic                     s2_valid_reg;
   logic                     s2_first_reg;
   logic                     s2_last_reg;

   // S3: accumulator
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  acc_reg;
   logic                     s3_valid_reg;
   logic                     s3_last_reg;

   // S4: round, shift, narrow
   logic signed [ACC_W:0]    rounded_next;
   logic signed [ACC_W:0]    shifted_next;
   logic signed [OUT_W-1:0]  p_next;
   logic signed [OUT_W-1:0]  p_reg;
   logic                     out_valid_reg;
   logic                     emit_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_valid_reg <= 1'b0;
         s1_first_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
      end else if (ce) begin
         s1_a_reg     <= a;
         s1_b_reg     <= b;
         s1_valid_reg <= in_valid;
         s1_first_reg <= in_valid & acc_first;
         s1_last_reg  <= in_valid & acc_last;
      end
   end

   assign prod_next = s1_a_reg * s1_b_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_prod_reg  <= '0;
         s2_valid_reg <= 1'b0;
         s2_first_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
      end else if (ce) begin
         s2_prod_reg  <= prod_next;
         s2_valid_reg <= s1_valid_reg;
         s2_first_reg <= s1_first_reg;
         s2_last_reg  <= s1_last_reg;
      end
   end

   // A first marker reloads, silently dropping any unfinished partial sum.
   assign prod_ext = ACC_W'(s2_prod_reg);
   assign acc_next = s2_first_reg ? prod_ext : acc_reg + prod_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg      <= '0;
         s3_valid_reg <= 1'b0;
         s3_last_reg  <= 1'b0;
      end else if (ce) begin
         if (s2_valid_reg) begin
            acc_reg <= acc_next;
         end
         s3_valid_reg <= s2_valid_reg;
         s3_last_reg  <= s2_last_reg;
      end
   end

   // One guard bit keeps the rounding add from wrapping at the top of the range.
   assign rounded_next = {acc_reg[ACC_W-1], acc_reg} + ROUND_K;
   assign shifted_next = rounded_next >>> SHIFT;
   assign emit_next    = s3_valid_reg & s3_last_reg;

`ifdef MPC_MAC_SAT_EN
   localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

   logic [ACC_W:OUT_W] sign_diff;
   logic               ovf_next;
   logic               ovf_reg;

   // Out of range whenever any bit above the output sign differs from it.
   genvar gi;
   generate
      for (gi = OUT_W; gi <= ACC_W; gi++) begin : g_sign_diff
         assign sign_diff[gi] = shifted_next[gi] ^ shifted_next[OUT_W-1];
      end
   endgenerate

   assign ovf_next = |sign_diff;
   assign p_next   = !ovf_next          ? shifted_next[OUT_W-1:0] :
                     shifted_next[ACC_W] ? OUT_MIN[OUT_W-1:0]      : OUT_MAX[OUT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (ce && emit_next) begin
         ovf_reg <= ovf_next;
      end
   end

   assign ovf = ovf_reg;
`else
   logic unused_shifted_hi;

   assign unused_shifted_hi = ^shifted_next[ACC_W:OUT_W];
   assign p_next            = shifted_next[OUT_W-1:0];
   assign ovf               = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else if (ce) begin
         if (emit_next) begin
            p_reg <= p_next;
         end
         out_valid_reg <= emit_next;
      end
   end

   assign p         = p_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mpc_mac_pipe.sv
// Directed bench for mpc_mac_pipe: single-term vector table plus multi-cycle frame sequences.
// Saturation expectations follow MPC_MAC_SAT_EN.
module tb_mpc_mac_pipe;

   localparam int A_W   = 21;
   localparam int B_W   = 13;
   localparam int ACC_W = 40;
   localparam int SHIFT = 10;
   localparam int OUT_W = 24;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    ce;
   logic                    in_valid;
   logic signed [A_W-1:0]   a;
   logic signed [B_W-1:0]   b;
   logic                    acc_first;
   logic                    acc_last;
   logic                    out_valid;
   logic signed [OUT_W-1:0] p;
   logic                    ovf;

   mpc_mac_pipe #(
      .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
   ) dut (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
      .acc_first(acc_first), .acc_last(acc_last),
      .out_valid(out_valid), .p(p), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int nres   = 0;
   int n0;

   // Frame results as a consumer sees them: out_valid qualified by ce.
   always @(negedge clk) begin
      if (!rst && out_valid && ce) nres++;
   end

   typedef struct {
      int a;
      int b;
      int exp_p;
   } vec_t;

   vec_t tbl[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic term(input int ta, input int tb, input bit f, input bit l);
      a         = ta[A_W-1:0];
      b         = tb[B_W-1:0];
      in_valid  = 1'b1;
      acc_first = f;
      acc_last  = l;
      tick();
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      acc_first = 1'b0;
      acc_last  = 1'b0;
      tick();
   endtask

   task automatic check_out(input string name, input int exp_p, input bit exp_ovf);
      check({name, "_ov"}, 64'(out_valid), 64'sd1);
      check({name, "_p"}, 64'($signed(p)), 64'(exp_p));
      check({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
   endtask

   initial begin
      tbl[0]  = '{1000, -300, -293};
      tbl[1]  = '{2048, 3, 6};
      tbl[2]  = '{1024, 7, 7};
      tbl[3]  = '{1024, -9, -9};
      tbl[4]  = '{0, 0, 0};
      tbl[5]  = '{-1, 1, 0};
      tbl[6]  = '{-512, 1, 0};
      tbl[7]  = '{-513, 1, -1};
      tbl[8]  = '{512, 1, 1};
      tbl[9]  = '{511, 1, 0};
      tbl[10] = '{-1048576, -4096, 4194304};

      rst = 1'b1; ce = 1'b1; in_valid = 1'b0;
      a = '0; b = '0; acc_first = 1'b0; acc_last = 1'b0;
      #12;
      check("reset_p", 64'($signed(p)), 64'sd0);
      check("reset_ov", 64'(out_valid), 64'sd0);
      check("reset_ovf", 64'(ovf), 64'sd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single-term frames: result after the fourth edge, never earlier.
      for (int i = 0; i < 11; i++) begin
         term(tbl[i].a, tbl[i].b, 1'b1, 1'b1);
         idle();
         idle();
         check($sformatf("vec%0d_early", i), 64'(out_valid), 64'sd0);
         idle();
         check_out($sformatf("vec%0d", i), tbl[i].exp_p, 1'b0);
      end
      idle();

      // Dot product with a bubble and a two-cycle ce stall after the last term.
      n0 = nres;
      term(100, 200, 1'b1, 1'b0);
      idle();
      term(-50, 400, 1'b0, 1'b0);
      term(300, -10, 1'b0, 1'b1);
      in_valid = 1'b0; acc_last = 1'b0; ce = 1'b0;
      tick();
      tick();
      check("dot_stall_ov", 64'(out_valid), 64'sd0);
      ce = 1'b1;
      idle();
      idle();
      check("dot_early", 64'(out_valid), 64'sd0);
      idle();
      check_out("dot", -3, 1'b0);
      idle();
      check("dot_pulse", 64'(out_valid), 64'sd0);
      check("dot_count", 64'(nres - n0), 64'sd1);

      // Four large negative terms overflow the 24-bit output.
      term(1048575, -4096, 1'b1, 1'b0);
      term(1048575, -4096, 1'b0, 1'b0);
      term(1048575, -4096, 1'b0, 1'b0);
      term(1048575, -4096, 1'b0, 1'b1);
      idle();
      idle();
      idle();
`ifdef MPC_MAC_SAT_EN
      check_out("sat", -8388608, 1'b1);
`else
      check_out("sat", 16, 1'b0);
`endif
      idle();

      // Restart: a first before last drops the partial frame.
      n0 = nres;
      term(1024, 1, 1'b1, 1'b0);
      term(1024, 1, 1'b0, 1'b0);
      term(1024, 5, 1'b1, 1'b1);
      idle();
      idle();
      idle();
      check_out("restart", 5, 1'b0);
      idle();
      idle();
      check("restart_count", 64'(nres - n0), 64'sd1);

      // Markers on invalid slots are ignored.
      n0 = nres;
      term(1024, 1, 1'b1, 1'b0);
      in_valid = 1'b0; acc_first = 1'b1; acc_last = 1'b1;
      tick();
      tick();
      term(1024, 2, 1'b0, 1'b1);
      idle();
      idle();
      idle();
      check_out("ignmark", 3, 1'b0);
      idle();
      check("ignmark_count", 64'(nres - n0), 64'sd1);

      // Asynchronous reset mid-frame.
      term(1000, 1000, 1'b1, 1'b0);
      term(1000, 1000, 1'b0, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      check("rst_async_p", 64'($signed(p)), 64'sd0);
      check("rst_async_ov", 64'(out_valid), 64'sd0);
      check("rst_async_ovf", 64'(ovf), 64'sd0);
      @(posedge clk);
      #1 rst = 1'b0;
      n0 = nres;
      term(2048, 3, 1'b1, 1'b1);
      idle();
      idle();
      idle();
      check_out("rst_frame", 6, 1'b0);
      idle();
      check("rst_count", 64'(nres - n0), 64'sd1);

      // After reset, terms without a first accumulate onto zero.
      term(1000, 1000, 1'b1, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      term(1024, 2, 1'b0, 1'b1);
      idle();
      idle();
      idle();
      check_out("rst_nofirst", 2, 1'b0);
      idle();

      // Back-to-back single-term frames.
      term(1024, 7, 1'b1, 1'b1);
      term(1024, -9, 1'b1, 1'b1);
      idle();
      idle();
      check_out("b2b_0", 7, 1'b0);
      idle();
      check_out("b2b_1", -9, 1'b0);
      idle();
      check("b2b_end", 64'(out_valid), 64'sd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mpc_mac_pipe.md
# mpc_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the MPC datapath. It is the successor to the fixed-width 4-stage DSP48 multipliers. It accumulates a stream of signed `a*b` terms framed by first/last markers, then rounds, shifts and narrows the sum to the output width. It serves the dot-product and matrix-row loops of the solver; a single-term frame yields a plain rounded product.

## Interface
Parameters:
- `A_W`, 21, width of signed operand `a`
- `B_W`, 13, width of signed operand `b`
- `ACC_W`, 40, signed accumulator width; must be ≥ `A_W+B_W`
- `SHIFT`, 10, arithmetic right shift applied to the final sum; 0 ≤ `SHIFT` < `ACC_W`
- `OUT_W`, 24, signed output width; `OUT_W` ≤ `ACC_W-SHIFT`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous and active-high
- `ce`  in  1  clock enable; when low, every register holds
- `in_valid`  in  1  `a`/`b`/markers valid this cycle
- `a`  in  `A_W`  signed operand
- `b`  in  `B_W`  signed operand
- `acc_first`  in  1  term starts a new frame; qualified by `in_valid`
- `acc_last`  in  1  term ends the frame and triggers output; qualified by `in_valid`
- `out_valid`  out  1  `p` holds a new frame result
- `p`  out  `OUT_W`  rounded, shifted, narrowed sum
- `ovf`  out  1  result was clamped (see Configuration)

## Operation
- The pipeline has four stages. All stages advance only on a rising `clk` edge with `ce`=1.
  - S1: register `a`, `b`, `in_valid`, `acc_first`, `acc_last`.
  - S2: form the full signed product (`A_W+B_W` bits). Carry valid and markers along.
  - S3: accumulate. A valid term with first=1 loads the sign-extended product. A valid term with first=0 adds the product. Invalid slots (bubbles) leave the accumulator unchanged.
  - S4: only on a valid term with last=1. Compute the S3 sum plus `2^(SHIFT-1)` (no add when `SHIFT`=0), arithmetic-shift right by `SHIFT`, then narrow to `OUT_W`. Register the result as `p` and set `out_valid`=1. Otherwise `out_valid`=0 and `p` holds its last value.
- The accumulator wraps modulo `2^ACC_W`. Sizing `ACC_W` for the frame length is the caller's responsibility.
- Rounding is round-half-up, i.e. towards +∞ on ties.
- Boundary conditions:
  - A term with first=1 and last=1 is a single-term frame.
  - First arriving before the previous last: the partial sum is silently discarded and no output is produced for it.
  - Valid terms before any first after reset accumulate onto 0.
  - `acc_first`/`acc_last` with `in_valid`=0 are ignored.
  - Back-to-back frames are allowed: last at cycle k and first at k+1 give one result per frame.
- Reset values: `p`=0, `out_valid`=0, `ovf`=0. The accumulator and all pipeline valids/markers are cleared. Reset mid-frame abandons the frame with no output.

## Timing
- Latency: a last term sampled at ce-enabled edge n produces `p`/`out_valid` after ce-enabled edge n+3 (fourth register). Each `ce`=0 cycle extends this by one cycle.
- Throughput: one term per ce-enabled cycle, with no stall or backpressure.
- `out_valid` is high for exactly one ce-enabled cycle per frame. During `ce`=0 it and `p` hold, so consumers qualify with `out_valid && ce`.

## Configuration
- Macro `MPC_MAC_SAT_EN`.
- Defined: the shifted sum is clamped to [`-2^(OUT_W-1)`, `2^(OUT_W-1)-1`]. `ovf`=1 with `out_valid` when clamping occurred, else 0; `ovf` holds with `p`.
- Undefined: narrowing keeps the low `OUT_W` bits (two's-complement wrap), and `ovf` is constant 0.

## Test plan
All scenarios use default parameters.
- Single term: `a`=1000, `b`=-300, first=last=1. Expect `p`=-293, `out_valid` on the 4th ce edge only, `ovf`=0.
- Dot product with stalls: (100,200,first), bubble, (-50,400), (300,-10,last), with `ce` low for 2 cycles mid-stream. Expect a single result `p`=-3, with latency extended by exactly 2 cycles.
- Saturation: four terms of `a`=1048575, `b`=-4096 (first on term 1, last on term 4). Expect `p`=-8388608 and `ovf`=1 with macro defined. Without the macro expect `p`=16 and `ovf`=0.
- Restart: (1024,1,first), (1024,1), then (1024,5,first,last). Expect exactly one `out_valid`, `p`=5.
- Reset mid-frame: two terms (1000,1000), assert `rst` for 1 cycle. Expect outputs 0 immediately (async). Then (2048,3,first,last) gives `p`=6 with no residue.
- Back-to-back frames: (1024,7,first,last) then (1024,-9,first,last) on consecutive cycles. Expect `p`=7 then `p`=-9 on consecutive cycles, `out_valid` high both.
